pulse_train_gen: RTL and testbench
==================================

// Module: pulse_train_gen
// PURPOSE
//  Output-side counterpart of the button pulse detector. A one-cycle start strobe
//  (e.g. from the detector) makes this block emit a burst of timed pulses on
//  pulse_out (LED/buzzer drive).
//  Runs on the 200 Hz system clock. One request can be queued while a burst is active.
// PARAMETERS
//  HIGH_CYC  20  clk cycles pulse_out is high per pulse (>=1; 20 = 100 ms)
//  LOW_CYC   20  clk cycles pulse_out is low after each pulse (>=1)
//  CNT_W     4   width of burst_len; max burst = 2**CNT_W-1 pulses
// PORTS
//  clk_200h   in   1      system clock, 200 Hz, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      one-cycle request strobe
//  burst_len  in   CNT_W  pulses requested; sampled only when start=1
//  pulse_out  out  1      registered pulse train
//  busy       out  1      1 while a burst (HIGH or LOW phase) is in progress
//  done       out  1      one-cycle strobe: last LOW phase of a burst just finished
//  drop       out  1      one-cycle strobe: request lost because the pending slot was full
// BEHAVIOUR
//  - All outputs are registered. Reset (async, rst_n=0): state=IDLE, pending slot empty,
//    and pulse_out/busy/done/drop are 0 immediately. A reset mid-burst discards the
//    burst and any pending request. Nothing resumes after release.
//  - FSM states: IDLE, HIGH, LOW.
//    * IDLE: start=1 with burst_len!=0 at edge k -> HIGH from cycle k+1. rem=burst_len.
//      timer=HIGH_CYC-1.
//    * HIGH: pulse_out=1. At timer==0 -> LOW, timer=LOW_CYC-1, rem=rem-1.
//    * LOW: pulse_out=0. At timer==0:
//      - rem!=0 -> HIGH.
//      - rem==0 and pending valid -> HIGH with rem=pending length; slot cleared.
//      - rem==0 and no pending -> IDLE.
//    * In both rem==0 cases, done=1 in the following cycle.
//  - busy=1 in every HIGH/LOW cycle, 0 in IDLE. One pulse period = HIGH_CYC+LOW_CYC
//    cycles. A burst of N pulses occupies N*(HIGH_CYC+LOW_CYC) cycles.
//  - burst_len==0 with start: ignored in every state. No done, no drop, no pending entry.
//  - start while busy:
//    * pending empty -> store burst_len.
//    * pending full -> drop=1 next cycle; the stored entry is kept.
//  - Same-cycle cases:
//    * start on the final LOW cycle with pending empty -> new burst begins the next
//      cycle with no IDLE gap; done still pulses.
//    * start on the final LOW cycle with pending full -> pending is consumed, the new
//      request takes the slot, no drop.
//  - Timer width = $clog2(max(HIGH_CYC,LOW_CYC)). rem is CNT_W bits and never wraps:
//    decrement only when rem!=0.
//  - drop and done never assert in IDLE except the done cycle that follows a burst.
// STRUCTURE
//  - Shared package pulse_pkg: state encoding localparams (ST_IDLE/ST_HIGH/ST_LOW),
//    CLK_HZ=200, and a ms-to-cycles constant function (shared with the button
//    pulse detector).
//  - One sub-module: pulse_timer (loadable down-counter, load value + zero flag), used
//    for the HIGH/LOW phases.
//  - FSM, rem counter and pending slot live in the top module.
// TESTING  (bench overrides HIGH_CYC=2, LOW_CYC=3, CNT_W=4; start strobed at cycle 0)
//  1. rst_n=0 held 3 cycles, inputs toggling -> pulse_out=busy=done=drop=0 throughout.
//  2. start, burst_len=3 -> pulse_out=1 in cycles 1-2, 6-7, 11-12, otherwise 0;
//     busy=1 in cycles 1-15; done=1 only in cycle 16; busy=0 from cycle 16.
//  3. start, burst_len=0 -> no pulse_out, busy, done or drop for 20 cycles.
//  4. len=1 at cycle 0, len=2 at cycle 2, len=4 at cycle 3 ->
//     drop=1 in cycle 4; done=1 in cycle 6;
//     pulse_out=1 in cycles 6-7 and 11-12 (len 2 runs back-to-back); done=1 in cycle 16.
//  5. len=2 at cycle 0, rst_n=0 at cycle 2 (mid HIGH) -> all outputs 0 immediately;
//     after release, IDLE and no pulses until the next start.
//  6. len=1 at cycle 0, len=1 at cycle 5 (final LOW cycle) -> done=1 and pulse_out=1
//     in cycle 6; busy stays 1 with no gap; drop stays 0.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the button pulse detector and the pulse train generator:
// FSM state encoding, system clock rate and a ms-to-cycles helper.
package pulse_pkg;

  localparam int unsigned CLK_HZ = 200;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (ms * CLK_HZ) / 1000;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter that parks at zero; times the HIGH and LOW phases.
module pulse_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits a burst of timed pulses on pulse_out per start strobe; one request can be
// queued while a burst is running.
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int unsigned HIGH_CYC = ms_to_cycles(100),
  parameter int unsigned LOW_CYC  = ms_to_cycles(100),
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk_200h,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             drop
);

  localparam int unsigned MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] HIGH_VAL = TMR_W'(HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] LOW_VAL  = TMR_W'(LOW_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pend_v_q, pend_v_d;
  logic [CNT_W-1:0] pend_len_q, pend_len_d;
  logic             pulse_out_q, busy_q, done_q, drop_q;
  logic             done_d, drop_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             start_ok;
  logic             final_low;

  pulse_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk_200h),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    pend_v_d   = pend_v_q;
    pend_len_d = pend_len_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    start_ok   = start && (burst_len != '0);
    final_low  = (state_q == ST_LOW) && tmr_zero && (rem_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_HIGH;
          rem_d    = burst_len;
          tmr_load = 1'b1;
          tmr_val  = HIGH_VAL;
        end
      end
      ST_HIGH: begin
        if (tmr_zero) begin
          state_d  = ST_LOW;
          tmr_load = 1'b1;
          tmr_val  = LOW_VAL;
          if (rem_q != '0) begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
      end
      ST_LOW: begin
        if (tmr_zero) begin
          if (rem_q != '0) begin
            state_d  = ST_HIGH;
            tmr_load = 1'b1;
            tmr_val  = HIGH_VAL;
          end else begin
            done_d = 1'b1;
            if (pend_v_q) begin
              state_d  = ST_HIGH;
              rem_d    = pend_len_q;
              pend_v_d = 1'b0;
              tmr_load = 1'b1;
              tmr_val  = HIGH_VAL;
            end else if (start_ok) begin
              state_d  = ST_HIGH;
              rem_d    = burst_len;
              tmr_load = 1'b1;
              tmr_val  = HIGH_VAL;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A request on the final LOW cycle either started directly above, or refills
    // the slot that is being consumed this same cycle.
    if (start_ok && (state_q != ST_IDLE) && !(final_low && !pend_v_q)) begin
      if (!pend_v_q || final_low) begin
        pend_v_d   = 1'b1;
        pend_len_d = burst_len;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_200h or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_len_q  <= '0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      pend_v_q    <= pend_v_d;
      pend_len_q  <= pend_len_d;
      pulse_out_q <= (state_d == ST_HIGH);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
      drop_q      <= drop_d;
    end
  end

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed cycle tables plus randomized traffic
// against a burst-schedule reference model.
module tb_pulse_train_gen;

  localparam int H = 2;
  localparam int L = 3;
  localparam int P = H + L;

  logic       clk_200h = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic [3:0] burst_len = 4'd0;
  logic       pulse_out, busy, done, drop;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: an active burst is described by its first HIGH cycle and
  // its pulse count; plus a single pending slot.
  bit m_act, m_pv, m_done, m_drop;
  int m_s, m_n, m_pn;

  pulse_train_gen #(
    .HIGH_CYC(H),
    .LOW_CYC (L),
    .CNT_W   (4)
  ) dut (
    .clk_200h (clk_200h),
    .rst_n    (rst_n),
    .start    (start),
    .burst_len(burst_len),
    .pulse_out(pulse_out),
    .busy     (busy),
    .done     (done),
    .drop     (drop)
  );

  always #5 clk_200h = ~clk_200h;

  function automatic void model_reset();
    m_act = 0; m_pv = 0; m_done = 0; m_drop = 0;
    m_s = 0; m_n = 0; m_pn = 0;
  endfunction

  function automatic void model_edge(input bit st, input int len);
    bit end_now;
    end_now = m_act && (cyc == m_s + m_n * P - 1);
    m_done = end_now;
    m_drop = 0;
    if (end_now) begin
      if (m_pv) begin
        m_s = cyc + 1; m_n = m_pn; m_pv = 0;
      end else begin
        m_act = 0;
      end
    end
    if (st && len != 0) begin
      if (!m_act) begin
        m_act = 1; m_s = cyc + 1; m_n = len;
      end else if (!m_pv) begin
        m_pv = 1; m_pn = len;
      end else begin
        m_drop = 1;
      end
    end
  endfunction

  function automatic logic [3:0] model_out();
    logic p;
    p = m_act && (((cyc - m_s) % P) < H);
    return {p, m_act, m_done, m_drop};
  endfunction

  // Apply inputs for the current cycle, advance one edge, land #1 after it.
  task automatic tick(input bit st, input int len);
    start     = st;
    burst_len = 4'(len);
    @(posedge clk_200h);
    if (rst_n) model_edge(st, len);
    else       model_reset();
    cyc++;
    #1;
    start     = 1'b0;
    burst_len = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst_n = 1'b0;
    model_reset();
    #1;
    obs = {pulse_out, busy, done, drop};
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_initial got=%b want=0000", obs);
    end
    for (int i = 0; i < 3; i++) begin
      tick($urandom_range(0, 1), $urandom_range(0, 15));
      obs = {pulse_out, busy, done, drop};
      n_cmp++;
      if (obs !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000", i, obs);
      end
    end
    rst_n = 1'b1;
    tick(0, 0);
  endtask

  task automatic test_single();
    logic [3:0] obs, exp;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        exp = {(k == 1 || k == 2 || k == 6 || k == 7 || k == 11 || k == 12),
               (k <= 15), (k == 16), 1'b0};
        obs = {pulse_out, busy, done, drop};
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL single_len3 k=%0d got=%b want=%b", k, obs, exp);
        end
      end
      tick(k == 0, 3);
    end
  endtask

  task automatic test_zero_len();
    logic [3:0] obs;
    tick(1, 0);
    for (int k = 1; k <= 20; k++) begin
      obs = {pulse_out, busy, done, drop};
      n_cmp++;
      if (obs !== 4'b0000) begin
        n_fail++;
        $display("FAIL zero_len k=%0d got=%b want=0000", k, obs);
      end
      tick((k % 3) == 0, 0);
    end
  endtask

  task automatic test_queue_drop();
    logic [3:0] obs, exp;
    int len;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        exp = {(k == 1 || k == 2 || k == 6 || k == 7 || k == 11 || k == 12),
               (k <= 15), (k == 6 || k == 16), (k == 4)};
        obs = {pulse_out, busy, done, drop};
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL queue_drop k=%0d got=%b want=%b", k, obs, exp);
        end
      end
      len = (k == 0) ? 1 : (k == 2) ? 2 : (k == 3) ? 4 : 0;
      tick(len != 0, len);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs;
    tick(1, 2);
    tick(0, 0);
    n_cmp++;
    if (pulse_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_pre got=%b want=1", pulse_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    obs = {pulse_out, busy, done, drop};
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_async got=%b want=0000", obs);
    end
    tick(0, 0);
    tick(1, 5);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(0, 0);
      obs = {pulse_out, busy, done, drop};
      n_cmp++;
      if (obs !== 4'b0000) begin
        n_fail++;
        $display("FAIL mid_reset_after k=%0d got=%b want=0000", k, obs);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        exp = {(k == 1 || k == 2 || k == 6 || k == 7),
               (k <= 10), (k == 6 || k == 11), 1'b0};
        obs = {pulse_out, busy, done, drop};
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL back_to_back k=%0d got=%b want=%b", k, obs, exp);
        end
      end
      tick(k == 0 || k == 5, 1);
    end
  endtask

  task automatic test_random();
    logic [3:0] obs, exp;
    bit st;
    int len;
    for (int i = 0; i < 800; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      len = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      tick(st, len);
      exp = model_out();
      obs = {pulse_out, busy, done, drop};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random i=%0d st=%0d len=%0d got=%b want=%b", i, st, len, obs, exp);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_zero_len();
    test_queue_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
